// File: rtl/lm71_spi3w_ctrl_if.sv
// Purpose : Wishbone classic bus bundle between a bus master and the LM71 controller.
// Latency : n/a (wiring only).
// Backpressure: the master holds cyc/stb until it sees o_wb_ack.
// Signals : i_wb_adr/i_wb_dat/i_wb_sel/i_wb_we/i_wb_cyc/i_wb_stb toward the slave,
//           o_wb_rdt/o_wb_ack back to the master. Modports: master, slave.
interface lm71_spi3w_ctrl_if;
   logic [1:0]  i_wb_adr;
   logic [31:0] i_wb_dat;
   logic [3:0]  i_wb_sel;
   logic        i_wb_we;
   logic        i_wb_cyc;
   logic        i_wb_stb;
   logic [31:0] o_wb_rdt;
   logic        o_wb_ack;

   modport master (output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
                   input  o_wb_rdt, o_wb_ack);
   modport slave  (input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
                   output o_wb_rdt, o_wb_ack);
endinterface

// File: rtl/lm71_spi3w_ctrl.sv
// Purpose : Wishbone slave driving the LM71 3-wire SPI sensor (16-bit read, optional 16-bit command write).
// Latency : bus ack 1 cycle after cyc&stb; BUSY and cs_n assert on the edge that samples START (the ack
//           cycle), BUSY clears exactly 34*CLK_DIV (66*CLK_DIV with WR_EN) cycles after that edge.
// Backpressure: no bus stalls; ack never in consecutive cycles, START while BUSY is dropped.
// Ports   : i_clk, i_rst_n (async, active low); wb (Wishbone slave modport);
//           o_temp_sc/o_temp_cs_n/o_temp_so/o_temp_so_oe pad controls, i_temp_si SIO pad value;
//           o_irq = DONE & IE.
// Config  : define LM71_SIGN_EXT_EN to make TEMP reads return bits[15:2] sign-extended.
module lm71_spi3w_ctrl #(
   parameter int CLK_DIV = 25
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   lm71_spi3w_ctrl_if.slave wb,
   output logic             o_temp_sc,
   output logic             o_temp_cs_n,
   input  logic             i_temp_si,
   output logic             o_temp_so,
   output logic             o_temp_so_oe,
   output logic             o_irq
);
   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_READ, S_WRITE, S_HOLD} state_t;

   localparam logic [15:0] TC = 16'(CLK_DIV - 1);

   state_t      state_q;
   logic [15:0] div_q;
   logic [15:0] cmd_q, cmd_sh_q, shift_q, temp_q;
   logic [4:0]  bit_q;
   logic        busy_q, done_q, ie_q, wr_en_q, wr_sh_q, ack_q;
   logic [31:0] rdt_q, rd_dat_d;
   logic        sc_q, cs_n_q, so_q, so_oe_q;

   logic acc, ctrl_wr, start_ok, tick, done_set;
   logic unused_wb;

   // A new access is only accepted when no ack is outstanding, which also
   // produces the 1,0,1,0 ack pattern for a held strobe.
   assign acc      = wb.i_wb_cyc & wb.i_wb_stb & ~ack_q;
   assign ctrl_wr  = acc & wb.i_wb_we & (wb.i_wb_adr == 2'd0);
   assign start_ok = ctrl_wr & wb.i_wb_dat[0] & ~busy_q;
   assign tick     = busy_q & (div_q == TC);
   assign done_set = tick & (state_q == S_HOLD);
   assign unused_wb = ^{wb.i_wb_sel, wb.i_wb_dat[31:16]};

   always_comb begin
      rd_dat_d = '0;
      case (wb.i_wb_adr)
         2'd0: rd_dat_d = {28'd0, wr_en_q, ie_q, done_q, busy_q};
         2'd1: rd_dat_d = {16'd0, cmd_q};
`ifdef LM71_SIGN_EXT_EN
         2'd2: rd_dat_d = {{18{temp_q[15]}}, temp_q[15:2]};
`else
         2'd2: rd_dat_d = {16'd0, temp_q};
`endif
         default: rd_dat_d = '0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         div_q    <= '0;
         cmd_q    <= '0;
         cmd_sh_q <= '0;
         shift_q  <= '0;
         temp_q   <= '0;
         bit_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ie_q     <= 1'b0;
         wr_en_q  <= 1'b0;
         wr_sh_q  <= 1'b0;
         ack_q    <= 1'b0;
         rdt_q    <= '0;
         sc_q     <= 1'b0;
         cs_n_q   <= 1'b1;
         so_q     <= 1'b0;
         so_oe_q  <= 1'b0;
      end else begin
         ack_q <= acc;
         if (acc && !wb.i_wb_we) rdt_q <= rd_dat_d;
         if (ctrl_wr) begin
            ie_q    <= wb.i_wb_dat[2];
            wr_en_q <= wb.i_wb_dat[1];
         end
         if (acc && wb.i_wb_we && wb.i_wb_adr == 2'd1) cmd_q <= wb.i_wb_dat[15:0];
         // Completion beats a simultaneous DONE_CLR.
         if (done_set) done_q <= 1'b1;
         else if (ctrl_wr && wb.i_wb_dat[3]) done_q <= 1'b0;

         if (!busy_q || tick) div_q <= '0;
         else div_q <= div_q + 16'd1;

         case (state_q)
            S_IDLE: if (start_ok) begin
               cmd_sh_q <= cmd_q;
               wr_sh_q  <= wb.i_wb_dat[1];
               busy_q   <= 1'b1;
               cs_n_q   <= 1'b0;
               bit_q    <= '0;
               state_q  <= S_SETUP;
            end
            S_SETUP: if (tick) begin
               sc_q    <= 1'b1;
               state_q <= S_READ;
            end
            // The 32nd half-period is the low phase after the last sample;
            // it ends the state instead of raising SC again.
            S_READ: if (tick) begin
               if (sc_q) begin
                  shift_q <= {shift_q[14:0], i_temp_si};
                  sc_q    <= 1'b0;
                  bit_q   <= bit_q + 5'd1;
               end else if (bit_q == 5'd16) begin
                  bit_q <= '0;
                  if (wr_sh_q) begin
                     so_oe_q <= 1'b1;
                     so_q    <= cmd_sh_q[15];
                     state_q <= S_WRITE;
                  end else begin
                     state_q <= S_HOLD;
                  end
               end else begin
                  sc_q <= 1'b1;
               end
            end
            // SO advances on the falling tick so it is stable across every rising edge.
            S_WRITE: if (tick) begin
               if (!sc_q) begin
                  sc_q <= 1'b1;
               end else begin
                  sc_q  <= 1'b0;
                  bit_q <= bit_q + 5'd1;
                  if (bit_q == 5'd15) begin
                     so_oe_q <= 1'b0;
                     so_q    <= 1'b0;
                     state_q <= S_HOLD;
                  end else begin
                     so_q     <= cmd_sh_q[14];
                     cmd_sh_q <= {cmd_sh_q[14:0], 1'b0};
                  end
               end
            end
            S_HOLD: if (tick) begin
               cs_n_q  <= 1'b1;
               temp_q  <= shift_q;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign wb.o_wb_ack  = ack_q;
   assign wb.o_wb_rdt  = rdt_q;
   assign o_temp_sc    = sc_q;
   assign o_temp_cs_n  = cs_n_q;
   assign o_temp_so    = so_q;
   assign o_temp_so_oe = so_oe_q;
   assign o_irq        = done_q & ie_q;
endmodule

// File: tb/tb_lm71_spi3w_ctrl.sv
// Purpose : Randomized self-checking bench for lm71_spi3w_ctrl with an LM71 sensor model.
// Latency : n/a.
// Backpressure: bus master waits for ack with a bounded cycle budget.
module tb_lm71_spi3w_ctrl;
   localparam int D = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lm71_spi3w_ctrl_if bus();
   logic sc, cs_n, si, so, so_oe, irq;

   lm71_spi3w_ctrl #(.CLK_DIV(D)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .wb(bus),
      .o_temp_sc(sc), .o_temp_cs_n(cs_n), .i_temp_si(si),
      .o_temp_so(so), .o_temp_so_oe(so_oe), .o_irq(irq)
   );

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
   endtask

   // ---------------- sensor model ----------------
   logic [15:0] sens_word = 16'hBEEF;
   logic [15:0] cap = '0;
   int rd_idx = -1, sc_rise = 0, cap_n = 0;
   always @(negedge cs_n) rd_idx = 15;
   always @(negedge sc) if (!cs_n) rd_idx--;
   always @(posedge sc) if (!cs_n) begin
      sc_rise++;
      if (so_oe) begin
         cap = {cap[14:0], so};
         cap_n++;
      end
   end
   assign si = so_oe ? so : ((rd_idx >= 0) ? sens_word[rd_idx[3:0]] : 1'b1);

   // ---------------- pin monitor ----------------
   int cur_low = 0, last_low = 0, oe_cyc = 0, viol = 0;
   always @(negedge clk) begin
      if (cs_n && (sc || so_oe)) viol++;
      if (!cs_n) begin
         cur_low++;
         if (so_oe) oe_cyc++;
      end else if (cur_low != 0) begin
         last_low = cur_low;
         cur_low  = 0;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct { bit rd; logic [1:0] adr; logic [31:0] exp; } sb_t;
   sb_t sbq[$];
   logic prev_ack = 1'b0;
   always @(negedge clk) begin
      sb_t e;
      if (rst_n && bus.o_wb_ack) begin
         chk("ack_not_consecutive", {31'd0, prev_ack}, 32'd0);
         if (sbq.size() == 0) chk("spurious_ack", 32'd1, 32'd0);
         else begin
            e = sbq.pop_front();
            if (e.rd) chk($sformatf("rd_adr%0d", e.adr), bus.o_wb_rdt, e.exp);
         end
      end
      prev_ack = bus.o_wb_ack;
   end

   // ---------------- reference model ----------------
   bit m_ie, m_wr, m_done, m_busy;
   logic [15:0] m_cmd, m_temp;

   function automatic logic [31:0] temp_view(input logic [15:0] w);
      int v;
`ifdef LM71_SIGN_EXT_EN
      v = int'($signed(w));
      return 32'(v >>> 2);
`else
      v = int'(w);
      return 32'(v);
`endif
   endfunction

   function automatic logic [31:0] ctrl_view();
      return {28'd0, m_wr, m_ie, m_done, m_busy};
   endfunction

   // ---------------- bus master ----------------
   task automatic wb_xfer(input logic [1:0] a, input bit we, input logic [31:0] d, input logic [31:0] exp);
      int n = 0;
      sb_t e;
      e.rd = !we; e.adr = a; e.exp = exp;
      sbq.push_back(e);
      @(posedge clk); #1;
      bus.i_wb_adr = a; bus.i_wb_we = we; bus.i_wb_dat = d;
      bus.i_wb_sel = 4'hF; bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!bus.o_wb_ack && n < 8);
      if (!bus.o_wb_ack) chk("ack_timeout", 32'd0, 32'd1);
      bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp);
      wb_xfer(a, 1'b0, 32'd0, exp);
   endtask

   task automatic ctrl_write(input logic [3:0] f);
      m_ie = f[2];
      m_wr = f[1];
      if (f[3]) m_done = 1'b0;
      wb_xfer(2'd0, 1'b1, {28'($urandom()), f}, 32'd0);
   endtask

   task automatic cmd_write(input logic [15:0] c);
      m_cmd = c;
      wb_xfer(2'd1, 1'b1, {16'($urandom()), c}, 32'd0);
   endtask

   task automatic run_txn(input logic [15:0] word, input logic [15:0] cmd, input bit wr,
                          input bit ie, input bit poke, input bit clr);
      int n = 0;
      sens_word = word;
      cmd_write(cmd);
      rd(2'd1, {16'd0, m_cmd});
      sc_rise = 0; cap = '0; cap_n = 0; oe_cyc = 0;
      ctrl_write({clr, ie, wr, 1'b1});
      m_busy = 1'b1;
      rd(2'd0, ctrl_view());
      if (poke) begin
         repeat (5 * D) @(posedge clk);
         ctrl_write({1'b0, ie, ~wr, 1'b1});
      end
      while (!cs_n && n < 200 * D) begin
         @(posedge clk); #1;
         n++;
      end
      @(negedge clk); #1;
      if (!cs_n) chk("txn_timeout", 32'd0, 32'd1);
      m_busy = 1'b0; m_done = 1'b1; m_temp = word;
      chk("busy_len", last_low, wr ? 66 * D : 34 * D);
      chk("sc_rises", sc_rise, wr ? 32 : 16);
      chk("so_oe_cycles", oe_cyc, wr ? 32 * D : 0);
      if (wr) chk("sensor_cmd", {cap_n[15:0], cap}, {16'd16, cmd});
      chk("irq_level", {31'd0, irq}, {31'd0, m_done & m_ie});
      rd(2'd2, temp_view(m_temp));
      rd(2'd0, ctrl_view());
   endtask

   logic [3:0] pat;

   initial begin
      bus.i_wb_adr = '0; bus.i_wb_dat = '0; bus.i_wb_sel = '0;
      bus.i_wb_we = 1'b0; bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
      m_ie = 0; m_wr = 0; m_done = 0; m_busy = 0; m_cmd = '0; m_temp = '0;

      // reset state with the sensor driving SIO
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("rst_pins", {26'd0, cs_n, sc, so, so_oe, irq, bus.o_wb_ack}, 32'b100000);
      chk("rst_rdt", bus.o_wb_rdt, 32'd0);
      rd(2'd0, 32'd0);
      rd(2'd2, 32'd0);

      // directed: read-only, write 0xFFFF, irq + busy START + DONE_CLR, sign extension
      run_txn(16'h0C87, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
      run_txn(16'h5A3C, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
      run_txn(16'h93C1, 16'hA5A5, 1'b0, 1'b1, 1'b1, 1'b1);
      ctrl_write({1'b1, 1'b1, m_wr, 1'b0});
      @(posedge clk); #1;
      chk("irq_after_done_clr", {31'd0, irq}, 32'd0);
      rd(2'd0, ctrl_view());
      run_txn(16'hE703, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);

      // back-to-back reads with strobe held
      begin
         sb_t e;
         e.rd = 1'b1; e.adr = 2'd3; e.exp = 32'd0;
         sbq.push_back(e); sbq.push_back(e);
         @(posedge clk); #1;
         bus.i_wb_adr = 2'd3; bus.i_wb_we = 1'b0; bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
         pat = '0;
         for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            pat = {pat[2:0], bus.o_wb_ack};
         end
         bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
         chk("ack_pattern", {28'd0, pat}, 32'b1010);
      end

      // randomized transactions
      for (int k = 0; k < 6; k++) begin
         run_txn(16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // asynchronous reset in the middle of READ
      sens_word = 16'h7FFF;
      cmd_write(16'hC0DE);
      ctrl_write(4'b0011);
      m_busy = 1'b1;
      repeat (7 * D) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_pins", {27'd0, cs_n, sc, so, so_oe, irq}, 32'b10000);
      @(posedge clk); #1 rst_n = 1'b1;
      m_ie = 0; m_wr = 0; m_done = 0; m_busy = 0; m_cmd = '0; m_temp = '0;
      sbq.delete();
      rd(2'd2, 32'd0);
      rd(2'd0, ctrl_view());
      rd(2'd1, 32'd0);

      repeat (4) @(posedge clk);
      @(negedge clk); #1;
      chk("scoreboard_drained", sbq.size(), 32'd0);
      chk("sc_or_oe_while_cs_high", viol, 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end
endmodule
